// File: rtl/fir_tap_seq.sv
// fir_tap_seq: per-sample tap sequencer for a regfile-backed FIR.
// Each accepted sample is written into a circular history buffer and then
// the NTAPS most recent samples x[n-k] are read back and streamed to the MAC
// with their tap index. Taps older than the samples seen since reset/clr
// are presented as zero so the first outputs start from a clean history.
// The buffer wraps on DEPTH entries. DEPTH is expected to equal 2**ADDR_W.
//
// Frame timing (E0 = acceptance edge):
//   E0          : write issued (rf_wen for one cycle)
//   E1..E(N)    : reads issued for k = 0..N-1, one per cycle
//   E2..E(N+1)  : m_valid with tap k, one cycle after its read
// The final read is issued on the same edge that returns the sequencer to
// IDLE, so s_ready is already high while that read is in flight and the
// next sample can be taken at E(N+1). Throughput is one sample per N+1
// cycles, and s_ready and busy are never high together.
module fir_tap_seq #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int WIDTH  = 16,
  parameter int NTAPS  = 32
) (
  input  logic                     clk2,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [WIDTH-1:0]  s_data,
  output logic                     rf_wen,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic signed [WIDTH-1:0]  rf_din,
  output logic                     rf_ren,
  output logic [ADDR_W-1:0]        rf_raddr,
  input  logic signed [WIDTH-1:0]  rf_dout,
  output logic                     m_valid,
  output logic signed [WIDTH-1:0]  m_data,
  output logic [ADDR_W-1:0]        m_tap,
  output logic                     m_first,
  output logic                     m_last,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  localparam logic [ADDR_W-1:0] LAST_TAP  = ADDR_W'(NTAPS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FILL_MAX  = (ADDR_W+1)'(NTAPS);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  state_t              state;
  logic [ADDR_W-1:0]   wptr;
  logic [ADDR_W:0]     fill;       // samples held before the current one
  logic [ADDR_W:0]     fill_now;   // samples held including the current one
  logic [ADDR_W-1:0]   tap_p0;     // tap index of the read in flight
  logic                first_p0;
  logic                last_p0;
  logic                keep_p0;    // read in flight carries real history
  logic                keep_p1;    // m_data passes rf_dout, else forced to 0
  logic [ADDR_W-1:0]   issue_k;
  logic                issue_last;

  // Saturating history count: one more sample, capped at the tap count.
  function automatic logic [ADDR_W:0] fill_sat(input logic [ADDR_W:0] f);
    if (f >= FILL_MAX) return FILL_MAX;
    return f + (ADDR_W+1)'(1);
  endfunction

  // Circular address (base - k) modulo DEPTH.
  function automatic logic [ADDR_W-1:0] wrap_sub(input logic [ADDR_W-1:0] base,
                                                 input logic [ADDR_W-1:0] k);
    logic [ADDR_W:0] t;
    if (base >= k) return base - k;
    t = {1'b0, base} + DEPTH_EXT - {1'b0, k};
    return t[ADDR_W-1:0];
  endfunction

  // Circular address base + 1 modulo DEPTH.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] base);
    if (base == LAST_ADDR) return '0;
    return base + ADDR_W'(1);
  endfunction

  // Tap index to be issued on the coming edge while in WRITE or READ.
  always_comb begin
    issue_k    = (state == WRITE) ? '0 : tap_p0 + ADDR_W'(1);
    issue_last = (issue_k == LAST_TAP);
  end

  // Sequencer, read-issue stage (_p0) and MAC output stage (_p1).
  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      wptr     <= '0;
      fill     <= '0;
      fill_now <= '0;
      s_ready  <= 1'b0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_din   <= '0;
      rf_ren   <= 1'b0;
      rf_raddr <= '0;
      tap_p0   <= '0;
      first_p0 <= 1'b0;
      last_p0  <= 1'b0;
      keep_p0  <= 1'b0;
      m_valid  <= 1'b0;
      m_tap    <= '0;
      m_first  <= 1'b0;
      m_last   <= 1'b0;
      keep_p1  <= 1'b0;
    end else if (clr) begin
      state   <= IDLE;
      wptr    <= '0;
      fill    <= '0;
      s_ready <= 1'b1;
      rf_wen  <= 1'b0;
      rf_ren  <= 1'b0;
      m_valid <= 1'b0;
      keep_p1 <= 1'b0;
    end else begin
      // --- stage p1: regfile data for the read issued last cycle is due now
      m_valid <= rf_ren;
      m_tap   <= tap_p0;
      m_first <= first_p0;
      m_last  <= last_p0;
      keep_p1 <= rf_ren & keep_p0;

      // --- stage p0: sequencer issues writes and reads
      rf_wen <= 1'b0;
      rf_ren <= 1'b0;
      case (state)
        IDLE: begin
          if (s_valid && s_ready) begin
            state    <= WRITE;
            s_ready  <= 1'b0;
            rf_wen   <= 1'b1;
            rf_waddr <= wptr;
            rf_din   <= s_data;
            fill_now <= fill_sat(fill);
          end else begin
            s_ready <= 1'b1;
          end
        end
        WRITE, READ: begin
          rf_ren   <= 1'b1;
          rf_raddr <= wrap_sub(wptr, issue_k);
          tap_p0   <= issue_k;
          first_p0 <= (issue_k == '0);
          last_p0  <= issue_last;
          keep_p0  <= ({1'b0, issue_k} < fill_now);
          if (issue_last) begin
            state   <= IDLE;
            s_ready <= 1'b1;
            wptr    <= wrap_inc(wptr);
            fill    <= fill_now;
          end else begin
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign m_data = keep_p1 ? rf_dout : '0;

endmodule

// File: tb/tb_fir_tap_seq.sv
// tb_fir_tap_seq: directed bench for fir_tap_seq with NTAPS=4, DEPTH=64.
// A behavioural regfile with one-cycle read latency sits on the rf_* port,
// and a shadow copy of the sample history supplies expected tap data for
// the longer runs.
module tb_fir_tap_seq;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int WIDTH  = 16;
  localparam int NTAPS  = 4;

  logic                    clk2 = 1'b0;
  logic                    rstn;
  logic                    clr;
  logic                    s_valid;
  logic                    s_ready;
  logic signed [WIDTH-1:0] s_data;
  logic                    rf_wen;
  logic [ADDR_W-1:0]       rf_waddr;
  logic signed [WIDTH-1:0] rf_din;
  logic                    rf_ren;
  logic [ADDR_W-1:0]       rf_raddr;
  logic signed [WIDTH-1:0] rf_dout;
  logic                    m_valid;
  logic signed [WIDTH-1:0] m_data;
  logic [ADDR_W-1:0]       m_tap;
  logic                    m_first;
  logic                    m_last;
  logic                    busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic signed [WIDTH-1:0] sh  [DEPTH];
  int sh_wp   = 0;
  int sh_fill = 0;

  fir_tap_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WIDTH(WIDTH), .NTAPS(NTAPS)) dut (
    .clk2(clk2), .rstn(rstn), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_din(rf_din),
    .rf_ren(rf_ren), .rf_raddr(rf_raddr), .rf_dout(rf_dout),
    .m_valid(m_valid), .m_data(m_data), .m_tap(m_tap),
    .m_first(m_first), .m_last(m_last), .busy(busy)
  );

  always #5 clk2 = ~clk2;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rf_dout = '0;
  end

  // Behavioural regfile: synchronous write, registered read.
  always @(posedge clk2) begin
    if (rf_wen) mem[rf_waddr] <= rf_din;
    if (rf_ren) rf_dout <= mem[rf_raddr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] pat(input int i);
    return 16'(i * 1021 - 30000);
  endfunction

  task automatic shadow_push(input logic signed [15:0] d);
    sh[sh_wp] = d;
    sh_wp = (sh_wp + 1) % DEPTH;
    if (sh_fill < NTAPS) sh_fill++;
  endtask

  task automatic shadow_clear();
    sh_wp = 0;
    sh_fill = 0;
  endtask

  // Offer one sample and check the write, the four reads and the four taps.
  // Entered and left on a falling edge with the sequencer idle.
  task automatic frame(input string tag, input logic signed [15:0] d, input logic [5:0] wa,
                       input logic [3:0][5:0] ra, input logic [3:0][15:0] md);
    int w;
    w = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && w < 20) begin
      @(negedge clk2);
      w++;
    end
    check({tag, "_accept"}, 16'(w < 20), 16'd1);
    @(negedge clk2);
    s_valid = 1'b0;
    check({tag, "_wen"}, 16'(rf_wen), 16'd1);
    check({tag, "_waddr"}, 16'(rf_waddr), 16'(wa));
    check({tag, "_din"}, rf_din, d);
    check({tag, "_ready_low"}, 16'(s_ready), 16'd0);
    check({tag, "_busy"}, 16'(busy), 16'd1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk2);
      if (c <= 4) begin
        check($sformatf("%s_ren%0d", tag, c - 1), 16'(rf_ren), 16'd1);
        check($sformatf("%s_raddr%0d", tag, c - 1), 16'(rf_raddr), 16'(ra[c-1]));
        check($sformatf("%s_wen_off%0d", tag, c), 16'(rf_wen), 16'd0);
      end else begin
        check({tag, "_ren_off"}, 16'(rf_ren), 16'd0);
      end
      if (c >= 2) begin
        check($sformatf("%s_mvalid%0d", tag, c - 2), 16'(m_valid), 16'd1);
        check($sformatf("%s_mdata%0d", tag, c - 2), m_data, md[c-2]);
        check($sformatf("%s_mtap%0d", tag, c - 2), 16'(m_tap), 16'(c - 2));
        check($sformatf("%s_mfirst%0d", tag, c - 2), 16'(m_first), 16'(c == 2));
        check($sformatf("%s_mlast%0d", tag, c - 2), 16'(m_last), 16'(c == 5));
      end else begin
        check({tag, "_mvalid_pre"}, 16'(m_valid), 16'd0);
      end
      if (c == 4) begin
        check({tag, "_ready_again"}, 16'(s_ready), 16'd1);
        check({tag, "_idle_again"}, 16'(busy), 16'd0);
      end
    end
    shadow_push(d);
  endtask

  // Frame whose expectations come from the shadow history.
  task automatic model_frame(input string tag, input logic signed [15:0] d);
    logic [3:0][5:0]  ra;
    logic [3:0][15:0] md;
    int fn;
    fn = (sh_fill < NTAPS) ? sh_fill + 1 : NTAPS;
    for (int k = 0; k < NTAPS; k++) begin
      ra[k] = 6'((sh_wp - k + DEPTH) % DEPTH);
      if (k >= fn)     md[k] = '0;
      else if (k == 0) md[k] = d;
      else             md[k] = sh[(sh_wp - k + DEPTH) % DEPTH];
    end
    frame(tag, d, 6'(sh_wp), ra, md);
  endtask

  initial begin
    int wr_first;
    int wr_second;
    int overlap;
    rstn    = 1'b0;
    clr     = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;

    // Reset held for three cycles
    repeat (3) @(negedge clk2);
    check("rst_s_ready", 16'(s_ready), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_rf_wen", 16'(rf_wen), 16'd0);
    check("rst_rf_ren", 16'(rf_ren), 16'd0);
    check("rst_rf_waddr", 16'(rf_waddr), 16'd0);
    check("rst_rf_raddr", 16'(rf_raddr), 16'd0);
    check("rst_rf_din", rf_din, 16'd0);
    check("rst_m_valid", 16'(m_valid), 16'd0);
    check("rst_m_data", m_data, 16'd0);
    check("rst_m_tap", 16'(m_tap), 16'd0);
    check("rst_m_first", 16'(m_first), 16'd0);
    check("rst_m_last", 16'(m_last), 16'd0);
    rstn = 1'b1;
    @(negedge clk2);
    check("rel_s_ready", 16'(s_ready), 16'd1);
    check("rel_busy", 16'(busy), 16'd0);

    // First sample into an empty history
    frame("first", 16'sh0100, 6'd0, '{6'd61, 6'd62, 6'd63, 6'd0},
          '{16'h0000, 16'h0000, 16'h0000, 16'h0100});

    // clr while idle, then five samples build up history
    clr = 1'b1;
    @(negedge clk2);
    clr = 1'b0;
    check("clr_idle_busy", 16'(busy), 16'd0);
    check("clr_idle_ready", 16'(s_ready), 16'd1);
    shadow_clear();
    frame("hist1", 16'sd1, 6'd0, '{6'd61, 6'd62, 6'd63, 6'd0}, '{16'd0, 16'd0, 16'd0, 16'd1});
    frame("hist2", 16'sd2, 6'd1, '{6'd62, 6'd63, 6'd0, 6'd1}, '{16'd0, 16'd0, 16'd1, 16'd2});
    frame("hist3", 16'sd3, 6'd2, '{6'd63, 6'd0, 6'd1, 6'd2}, '{16'd0, 16'd1, 16'd2, 16'd3});
    frame("hist4", 16'sd4, 6'd3, '{6'd0, 6'd1, 6'd2, 6'd3}, '{16'd1, 16'd2, 16'd3, 16'd4});
    frame("hist5", 16'sd5, 6'd4, '{6'd1, 6'd2, 6'd3, 6'd4}, '{16'd2, 16'd3, 16'd4, 16'd5});

    // Wrap-around: 65 samples from a cleared history
    clr = 1'b1;
    @(negedge clk2);
    clr = 1'b0;
    shadow_clear();
    for (int i = 1; i <= 64; i++) model_frame($sformatf("wrap%0d", i), pat(i));
    frame("wrap65", pat(65), 6'd0, '{6'd61, 6'd62, 6'd63, 6'd0},
          '{pat(62), pat(63), pat(64), pat(65)});

    // Backpressure: s_valid held across a whole frame
    wr_first  = -1;
    wr_second = -1;
    overlap   = 0;
    s_valid = 1'b1;
    s_data  = 16'sh1234;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk2);
      if (busy && s_ready) overlap++;
      if (rf_wen) begin
        if (wr_first < 0) begin
          wr_first = n;
          check("bp_din_a", rf_din, 16'h1234);
          s_data = -16'sd77;
        end else if (wr_second < 0) begin
          wr_second = n;
          check("bp_din_b", rf_din, 16'hffb3);
          s_valid = 1'b0;
        end
      end
    end
    check("bp_ready_vs_busy", 16'(overlap), 16'd0);
    check("bp_two_writes", 16'(wr_first > 0 && wr_second > 0), 16'd1);
    check("bp_spacing", 16'(wr_second - wr_first), 16'(NTAPS + 1));
    check("bp_settled", 16'(busy), 16'd0);

    // clr in the middle of a read sequence
    s_valid = 1'b1;
    s_data  = 16'sd9;
    @(negedge clk2);
    s_valid = 1'b0;
    @(negedge clk2);
    @(negedge clk2);
    check("clrmid_pre_mvalid", 16'(m_valid), 16'd1);
    clr = 1'b1;
    @(negedge clk2);
    clr = 1'b0;
    check("clrmid_mvalid", 16'(m_valid), 16'd0);
    check("clrmid_busy", 16'(busy), 16'd0);
    check("clrmid_ren", 16'(rf_ren), 16'd0);
    check("clrmid_wen", 16'(rf_wen), 16'd0);
    check("clrmid_ready", 16'(s_ready), 16'd1);
    shadow_clear();
    frame("after_clr", 16'sd7, 6'd0, '{6'd61, 6'd62, 6'd63, 6'd0}, '{16'd0, 16'd0, 16'd0, 16'd7});

    // Reset asserted mid-frame aborts at once
    s_valid = 1'b1;
    s_data  = 16'sd11;
    @(negedge clk2);
    s_valid = 1'b0;
    @(negedge clk2);
    #2 rstn = 1'b0;
    #1;
    check("rstmid_busy", 16'(busy), 16'd0);
    check("rstmid_ren", 16'(rf_ren), 16'd0);
    check("rstmid_raddr", 16'(rf_raddr), 16'd0);
    check("rstmid_ready", 16'(s_ready), 16'd0);
    @(negedge clk2);
    check("rstmid_mvalid", 16'(m_valid), 16'd0);
    rstn = 1'b1;
    @(negedge clk2);
    check("rstmid_rel_ready", 16'(s_ready), 16'd1);
    shadow_clear();
    frame("after_rst", 16'sh7fff, 6'd0, '{6'd61, 6'd62, 6'd63, 6'd0},
          '{16'd0, 16'd0, 16'd0, 16'h7fff});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_tap_seq.md
FIR_TAP_SEQ -- requirements
Module: fir_tap_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of sample-buffer entries in the attached regfile.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning the regfile address width, equal to log2(DEPTH).
REQ-003 SHALL have parameter WIDTH, default 16, meaning the signed sample width.
REQ-004 SHALL have parameter NTAPS, default 32, meaning the taps per output sample; legal range 1..DEPTH.
REQ-005 SHALL have port clk2, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port clr, input, 1 bit: synchronous flush of history and sequence.
REQ-008 SHALL have port s_valid, input, 1 bit: a new input sample is offered.
REQ-009 SHALL have port s_ready, output, 1 bit: the block accepts the sample this cycle.
REQ-010 SHALL have port s_data, input, signed WIDTH bits: the input sample.
REQ-011 SHALL have port rf_wen, output, 1 bit: regfile write enable.
REQ-012 SHALL have port rf_waddr, output, ADDR_W bits: regfile write address.
REQ-013 SHALL have port rf_din, output, signed WIDTH bits: regfile write data.
REQ-014 SHALL have port rf_ren, output, 1 bit: regfile read enable.
REQ-015 SHALL have port rf_raddr, output, ADDR_W bits: regfile read address.
REQ-016 SHALL have port rf_dout, input, signed WIDTH bits: regfile read data, valid 1 cycle after rf_ren.
REQ-017 SHALL have port m_valid, output, 1 bit: tap sample valid to the MAC; there is no backpressure.
REQ-018 SHALL have port m_data, output, signed WIDTH bits: the tap sample x[n-k].
REQ-019 SHALL have port m_tap, output, ADDR_W bits: tap index k.
REQ-020 SHALL have ports m_first and m_last, outputs, 1 bit each, asserted with tap k=0 and k=NTAPS-1 respectively.
REQ-021 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-022 SHALL implement states IDLE, WRITE and READ; all rf_* and m_* outputs are registered.
REQ-023 SHALL assert s_ready only in IDLE; on s_valid&&s_ready at edge E0 it SHALL enter WRITE.
REQ-024 In WRITE (cycle E0..E1) SHALL drive rf_wen=1, rf_waddr=wptr and rf_din=the captured s_data for exactly one cycle, then enter READ.
REQ-025 In READ SHALL assert rf_ren for NTAPS consecutive cycles starting at E1, with rf_raddr=(wptr-k) mod DEPTH for k=0..NTAPS-1 (modular wrap, no saturation).
REQ-026 SHALL drive m_valid in the cycle after each read, with m_tap=k, giving m_valid high for cycles E2..E(NTAPS+1).
REQ-027 SHALL drive m_data=rf_dout when k<fill and m_data=0 when k>=fill, where fill is the count of samples written since reset/clr (saturating at NTAPS, counted including the current sample).
REQ-028 After the last read SHALL set wptr=(wptr+1) mod DEPTH, update fill, and return to IDLE; s_ready SHALL be high again at E(NTAPS+1), giving a throughput of one sample per NTAPS+1 cycles.
REQ-029 When s_valid is high while not ready, SHALL not capture s_data; the source holds it until accepted.
REQ-030 Outside WRITE, rf_wen SHALL be 0; outside READ, rf_ren SHALL be 0; m_valid SHALL be 0 when no read data is due.
REQ-031 clr sampled high in any state SHALL, at that edge, force IDLE, wptr=0, fill=0, rf_wen=0 and rf_ren=0, and SHALL force m_valid=0 from the next cycle; clr SHALL take priority over s_valid.

Reset
REQ-032 While rstn=0 SHALL hold state=IDLE, wptr=0, fill=0, and drive s_ready=0, rf_wen=0, rf_ren=0, rf_waddr=0, rf_raddr=0, rf_din=0, m_valid=0, m_data=0, m_tap=0, m_first=0, m_last=0 and busy=0.
REQ-033 s_ready SHALL rise on the first clk2 edge after rstn deasserts; reset asserted mid-frame SHALL abort the frame immediately.

Verification
REQ-034 Bench SHALL check reset: rstn=0 for 3 cycles -> all outputs 0; one edge after release -> s_ready=1 and busy=0.
REQ-035 Bench SHALL check the first sample (NTAPS=4): s_data=0x0100 -> one rf_wen write with waddr=0 and din=0x0100; raddr sequence 0,63,62,61; m_data sequence 0x0100,0,0,0; m_first on k=0 and m_last on k=3.
REQ-036 Bench SHALL check history (NTAPS=4): samples 1,2,3,4,5 -> the fifth frame gives m_data 5,4,3,2 with m_tap 0..3.
REQ-037 Bench SHALL check wrap-around: 65 samples -> the 65th is written at waddr=0, reads 0,63,62,61, and m_data matches the shadow model.
REQ-038 Bench SHALL check backpressure: s_valid held high across a frame -> s_ready=0 while busy, and the next sample is accepted exactly NTAPS+1 cycles after the previous acceptance.
REQ-039 Bench SHALL check clr mid-READ: clr pulsed -> m_valid=0 next cycle, busy=0; the following sample 7 yields m_data 7,0,0,0.
